// File: rtl/pulse_train_gen.sv
// pulse_train_gen
//
// Sending end of the single-wire pulse-count interface used by the mod-4
// pulse-counting FSMs. A start request launches a burst of `count`
// single-cycle pulses on x_out, separated by `gap` idle cycles, and ends
// with a one-cycle done strobe. Alongside, a receiver-side model tracks
// how many pulses have gone out (mod 4) and what the detector should say.
//
// Parameters:
//   CNT_W     width of count (up to 2^CNT_W-1 pulses per burst)
//   GAP_W     width of gap (idle cycles between pulses)
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start     burst request, only honoured while idle
//   count     pulses in the burst, latched with an accepted start
//   gap       idle cycles between pulses, latched with an accepted start
//   phase_clr synchronous clear of the phase model (wins over a pulse)
//   x_out     serial pulse output
//   busy      high whenever a burst (including its done cycle) is active
//   done      one-cycle completion strobe
//   phase     pulses sent since the last clear, mod 4
//   y_exp     expected detector output, high when phase is 3
module pulse_train_gen #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [GAP_W-1:0] gap,
  input  logic             phase_clr,
  output logic             x_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       phase,
  output logic             y_exp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [1:0]       phase_q, phase_d;
  logic             x_out_q, busy_q, done_q, y_exp_q;

  // Next-state logic. rem holds the pulses still to send including the one
  // currently on the wire, so rem==1 in PULSE means this is the last pulse.
  // gcnt is loaded with the full gap and counts down to 1, giving exactly
  // `gap` idle cycles before the next pulse.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = count;
          gap_d   = gap;
          state_d = (count != '0) ? PULSE : DONE;
        end
      end
      PULSE: begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = DONE;
        end else if (gap_q == '0) begin
          state_d = PULSE;
        end else begin
          gcnt_d  = gap_q;
          state_d = GAP;
        end
      end
      GAP: begin
        gcnt_d = gcnt_q - GAP_W'(1);
        if (gcnt_q == GAP_W'(1)) begin
          state_d = PULSE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Phase model: counts each cycle x_out was high. A clear in the same
  // cycle as a pulse swallows that pulse.
  always_comb begin
    phase_d = phase_q;
    if (phase_clr) begin
      phase_d = 2'd0;
    end else if (x_out_q) begin
      phase_d = phase_q + 2'd1;
    end
  end

  // All state and the outputs decoded from the next state, so every output
  // comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      phase_q <= 2'd0;
      x_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_exp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      phase_q <= phase_d;
      x_out_q <= (state_d == PULSE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      y_exp_q <= (phase_d == 2'd3);
    end
  end

  assign x_out = x_out_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign phase = phase_q;
  assign y_exp = y_exp_q;

endmodule
